memtile_bus_arbiter_rr: RTL and testbench



---
 rtl/memtile_bus_arbiter_rr.sv | 63 ++++++
 tb/tb_memtile_bus_arbiter_rr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/memtile_bus_arbiter_rr.sv
// memtile_bus_arbiter_rr: round-robin bus arbiter with lock-until-release and optional hold limit
// Ports: clk      - rising-edge clock
//        rst_n    - asynchronous active-low reset
//        req      - per-master request, bit i = master i holds or wants the bus
//        gnt      - registered one-hot grant, always exactly one bit set
//        gnt_idx  - registered binary index of the granted master
//        preempt  - one-cycle pulse after a grant change forced by hold expiry
module memtile_bus_arbiter_rr #(
    parameter int PORTS = 4,
    parameter int MAX_HOLD = 0,
    localparam int IDXW = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int CNTW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] req,
    output logic [PORTS-1:0] gnt,
    output logic [IDXW-1:0]  gnt_idx,
    output logic             preempt
);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    logic [IDXW-1:0] cur, cand, nxt;
    logic [CNTW-1:0] hold_cnt, cnt_nxt;
    logic pending, own, expiry;
    // (c + k) mod PORTS without a divider; k is always below PORTS
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] c, input int k);
        int s;
        s = int'(c) + k;
        return IDXW'((s >= PORTS) ? s - PORTS : s);
    endfunction
    // Scan from the farthest offset down so the nearest requester after cur wins
    always_comb begin
        cand = cur;
        pending = 1'b0;
        for (int k = PORTS - 1; k >= 1; k--) begin
            if (req[wrap_add(cur, k)]) begin
                cand = wrap_add(cur, k);
                pending = 1'b1;
            end
        end
        own = req[cur];
        expiry = (MAX_HOLD != 0) && own && pending && (hold_cnt == HOLD_LAST);
        nxt = (pending && (!own || expiry)) ? cand : cur;
        cnt_nxt = (nxt != cur || !own || MAX_HOLD == 0) ? '0 :
                  (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
            hold_cnt <= '0;
            preempt <= 1'b0;
        end else begin
            cur <= nxt;
            hold_cnt <= cnt_nxt;
            preempt <= expiry;
        end
    end
    always_comb begin
        gnt = '0;
        gnt[cur] = 1'b1;
    end
    assign gnt_idx = cur;
endmodule

// File: tb/tb_memtile_bus_arbiter_rr.sv
// tb_memtile_bus_arbiter_rr: randomized and directed checks of three arbiter configurations against a reference model
module tb_memtile_bus_arbiter_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req_a = '0, req_b = '0, gnt_a, gnt_b;
    logic [2:0] req_c = '0, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic pre_a, pre_b, pre_c;
    int checks = 0;
    int failures = 0;
    int m_cur[3], m_cnt[3], m_pre[3];
    int wait_c[3];
    int max_wait = 0;

    always #5 clk = ~clk;

    memtile_bus_arbiter_rr #(.PORTS(4), .MAX_HOLD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a), .preempt(pre_a));
    memtile_bus_arbiter_rr #(.PORTS(4), .MAX_HOLD(4)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b), .preempt(pre_b));
    memtile_bus_arbiter_rr #(.PORTS(3), .MAX_HOLD(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c), .preempt(pre_c));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: the grant stays with its owner while requested, otherwise passes to the
    // nearest later requester; an owner that has held MAX_HOLD cycles with others waiting yields.
    task automatic model_step(input int i, input int n, input int mh, input logic [15:0] r);
        int nearest;
        int others;
        int pre;
        nearest = -1;
        others = 0;
        for (int k = 1; k < n; k++)
            if (r[(m_cur[i] + k) % n] && nearest < 0) nearest = (m_cur[i] + k) % n;
        others = (nearest >= 0) ? 1 : 0;
        pre = (mh != 0 && r[m_cur[i]] && others == 1 && m_cnt[i] == mh - 1) ? 1 : 0;
        if (others == 1 && (!r[m_cur[i]] || pre == 1)) begin
            m_cur[i] = nearest;
            m_cnt[i] = 0;
        end else if (r[m_cur[i]] && mh != 0) begin
            m_cnt[i] = (m_cnt[i] + 1 < mh) ? m_cnt[i] + 1 : mh - 1;
        end else begin
            m_cnt[i] = 0;
        end
        m_pre[i] = pre;
    endtask

    task automatic reset_models();
        for (int i = 0; i < 3; i++) begin
            m_cur[i] = 0;
            m_cnt[i] = 0;
            m_pre[i] = 0;
            wait_c[i] = 0;
        end
    endtask

    task automatic tick();
        logic [2:0] rc;
        int prev;
        rc = req_c;
        prev = int'(idx_c);
        model_step(0, 4, 0, 16'(req_a));
        model_step(1, 4, 4, 16'(req_b));
        model_step(2, 3, 2, 16'(req_c));
        @(posedge clk);
        #1;
        chk("a_gnt", int'(gnt_a), 1 << m_cur[0]);
        chk("a_idx", int'(idx_a), m_cur[0]);
        chk("a_pre", int'(pre_a), m_pre[0]);
        chk("b_gnt", int'(gnt_b), 1 << m_cur[1]);
        chk("b_idx", int'(idx_b), m_cur[1]);
        chk("b_pre", int'(pre_b), m_pre[1]);
        chk("c_gnt", int'(gnt_c), 1 << m_cur[2]);
        chk("c_idx", int'(idx_c), m_cur[2]);
        chk("c_pre", int'(pre_c), m_pre[2]);
        for (int i = 0; i < 3; i++) begin
            if (!rc[i] || gnt_c[i]) wait_c[i] = 0;
            else if (int'(idx_c) != prev) wait_c[i]++;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
    endtask

    initial begin
        reset_models();
        #2;
        chk("rst_a_gnt", int'(gnt_a), 1);
        chk("rst_a_idx", int'(idx_a), 0);
        chk("rst_a_pre", int'(pre_a), 0);
        chk("rst_b_gnt", int'(gnt_b), 1);
        chk("rst_c_gnt", int'(gnt_c), 1);
        #6 rst_n = 1'b1;
        repeat (3) tick();
        chk("park_a", int'(gnt_a), 1);
        req_a = 4'b1010;
        tick();
        chk("rr_a_first", int'(gnt_a), 4'b0010);
        req_a = 4'b1000;
        tick();
        chk("rr_a_second", int'(gnt_a), 4'b1000);
        req_a = 4'b0100;
        tick();
        chk("a_to_2", int'(gnt_a), 4'b0100);
        req_a = 4'b1111;
        repeat (100) tick();
        chk("lock_100", int'(gnt_a), 4'b0100);
        req_a = 4'b1011;
        tick();
        chk("unlock", int'(gnt_a), 4'b1000);
        req_b = 4'b0010;
        tick();
        chk("b_to_1", int'(gnt_b), 4'b0010);
        req_b = 4'b0011;
        repeat (3) begin
            tick();
            chk("hold1_gnt", int'(gnt_b), 4'b0010);
            chk("hold1_pre", int'(pre_b), 0);
        end
        tick();
        chk("expire1_gnt", int'(gnt_b), 4'b0001);
        chk("expire1_pre", int'(pre_b), 1);
        repeat (3) begin
            tick();
            chk("hold0_gnt", int'(gnt_b), 4'b0001);
            chk("hold0_pre", int'(pre_b), 0);
        end
        tick();
        chk("expire2_gnt", int'(gnt_b), 4'b0010);
        chk("expire2_pre", int'(pre_b), 1);
        req_c = 3'b100;
        tick();
        chk("c_to_2", int'(idx_c), 2);
        req_c = 3'b001;
        tick();
        chk("c_wrap", int'(idx_c), 0);
        req_b = 4'b1000;
        repeat (3) tick();
        chk("b_at_3", int'(gnt_b), 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", int'(gnt_b), 4'b0001);
        chk("async_rst_idx", int'(idx_b), 0);
        chk("async_rst_pre", int'(pre_b), 0);
        reset_models();
        #1 rst_n = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0011;
        req_c = 3'b000;
        repeat (3) begin
            tick();
            chk("post_rst_hold", int'(gnt_b), 4'b0001);
        end
        tick();
        chk("post_rst_exp_gnt", int'(gnt_b), 4'b0010);
        chk("post_rst_exp_pre", int'(pre_b), 1);
        for (int n = 0; n < 10000; n++) begin
            req_a = 4'($urandom);
            req_b = 4'($urandom);
            for (int i = 0; i < 3; i++)
                if ($urandom_range(3) == 0) req_c[i] = ~req_c[i];
            tick();
        end
        chk("c_starve_bound", (max_wait <= 2) ? 1 : 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
